enemy_formation: RTL and testbench

Parametrised controller for the invader grid: holds the formation origin, marches it horizontally with edge-aware turn-and-drop, tracks per-enemy alive state, speeds up as enemies die, selects which enemy fires next, and flags wipe-out and invasion. It sits between the game state machine (start/run), the collision logic (kill reports) and the per-enemy sprite renderers. Each renderer derives its own position as (base_x + col·DX, base_y + row·DY).

---
 rtl/enemy_formation.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_enemy_formation.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_formation.sv
// -----------------------------------------------------------------------------
// enemy_formation
//   Controller for the invader grid. Holds the formation origin and marches it
//   horizontally with an edge-aware turn-and-drop, keeps a per-enemy alive
//   bitmap, shortens the step period as enemies die, picks the next shooter
//   and flags wipe-out / invasion. Renderers place enemy (row, col) at
//   (base_x + col*DX, base_y + row*DY).
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   start         in   synchronous reload of origin, alive, direction, counters
//   run           in   march enable
//   kill_valid    in   one-cycle kill report
//   kill_idx      in   killed enemy index (row*COLS + col)
//   base_x/base_y out  formation origin
//   alive         out  per-enemy alive bitmap
//   direction     out  0 = marching right, 1 = marching left
//   step_pulse    out  one-cycle strobe in the cycle the new origin shows
//   shooter_idx   out  enemy designated to fire
//   shooter_valid out  at least one enemy alive
//   all_dead      out  no enemy alive
//   invaded       out  sticky: lowest live row reached Y_INVADE
// -----------------------------------------------------------------------------
module enemy_formation #(
  parameter int COLS      = 8,
  parameter int ROWS      = 3,
  parameter int X0        = 150,
  parameter int Y0        = 40,
  parameter int DX        = 60,
  parameter int DY        = 50,
  parameter int SPRITE_W  = 20,
  parameter int SPRITE_H  = 20,
  parameter int STEP_X    = 10,
  parameter int STEP_Y    = 20,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 640,
  parameter int Y_INVADE  = 400,
  parameter int TICK_BASE = 2_500_000,
  parameter int TICK_MIN  = 250_000,
  parameter int TICK_DEC  = 100_000,
  localparam int N        = ROWS * COLS,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          run,
  input  logic          kill_valid,
  input  logic [IW-1:0] kill_idx,
  output logic [10:0]   base_x,
  output logic [10:0]   base_y,
  output logic [N-1:0]  alive,
  output logic          direction,
  output logic          step_pulse,
  output logic [IW-1:0] shooter_idx,
  output logic          shooter_valid,
  output logic          all_dead,
  output logic          invaded
);

  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RLW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = $clog2(TICK_BASE + 1);
  localparam int DW  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MARCH, HALT} state_t;

  state_t          state_reg, state_next;
  logic [10:0]     base_x_reg, base_y_reg;
  logic [N-1:0]    alive_reg;
  logic            dir_reg;
  logic            step_pulse_reg;
  logic [IW-1:0]   shooter_idx_reg;
  logic [CLW-1:0]  shoot_col_reg;
  logic            invaded_reg;
  logic [CW-1:0]   tick_cnt_reg;
  logic [DW-1:0]   dead_reg;

  // ---------------------------------------------------------------------------
  // Occupancy summaries
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] col_alive;
  logic [ROWS-1:0] row_alive;
  logic            any_alive;

  genvar gi, gj;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [ROWS-1:0] col_bits;
      for (gj = 0; gj < ROWS; gj++) begin : g_bit
        assign col_bits[gj] = alive_reg[gj*COLS + gi];
      end
      assign col_alive[gi] = |col_bits;
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_alive[gi] = |alive_reg[gi*COLS +: COLS];
    end
  endgenerate

  assign any_alive = |alive_reg;

  // Rightmost / leftmost live column and lowest (largest index) live row.
  logic [CLW-1:0] rc, lc;
  logic [RLW-1:0] lr;

  always_comb begin
    rc = '0;
    lc = '0;
    lr = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_alive[c]) rc = CLW'(c);
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_alive[c]) lc = CLW'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_alive[r]) lr = RLW'(r);
    end
  end

  // ---------------------------------------------------------------------------
  // Step period: shrinks with each kill, saturating at TICK_MIN
  // ---------------------------------------------------------------------------
  logic [31:0] dec_w, period_w, cnt_ext;
  logic        tick_done;

  always_comb begin
    dec_w = 32'(dead_reg) * 32'(TICK_DEC);
    if (32'(TICK_BASE) <= 32'(TICK_MIN) + dec_w) period_w = 32'(TICK_MIN);
    else                                          period_w = 32'(TICK_BASE) - dec_w;
    cnt_ext   = 32'(tick_cnt_reg);
    // cnt+1 >= period avoids an underflow of period-1; ">=" also covers a
    // period that shrank below the running count after a mid-interval kill.
    tick_done = (cnt_ext + 32'd1) >= period_w;
  end

  // ---------------------------------------------------------------------------
  // Step geometry (12-bit unsigned so the sums never wrap at 11 bits)
  // ---------------------------------------------------------------------------
  logic [11:0] right_edge, left_edge, low_edge;
  logic        drop;
  logic [10:0] base_x_step, base_y_step;
  logic        dir_step;
  logic        invade_cond;

  always_comb begin
    right_edge = {1'b0, base_x_reg} + 12'(rc) * 12'(DX) + 12'(SPRITE_W) + 12'(STEP_X);
    left_edge  = {1'b0, base_x_reg} + 12'(lc) * 12'(DX);
    low_edge   = {1'b0, base_y_reg} + 12'(lr) * 12'(DY) + 12'(SPRITE_H);
    if (dir_reg) drop = left_edge < (12'(X_MIN) + 12'(STEP_X));
    else         drop = right_edge > 12'(X_MAX);
    base_x_step = base_x_reg;
    base_y_step = base_y_reg;
    dir_step    = dir_reg;
    if (drop) begin
      base_y_step = base_y_reg + 11'(STEP_Y);
      dir_step    = ~dir_reg;
    end else if (dir_reg) begin
      base_x_step = base_x_reg - 11'(STEP_X);
    end else begin
      base_x_step = base_x_reg + 11'(STEP_X);
    end
    invade_cond = low_edge >= 12'(Y_INVADE);
  end

  // ---------------------------------------------------------------------------
  // Shooter: next column (cyclically) that still holds a live enemy, then the
  // bottom-most live enemy in that column.
  // ---------------------------------------------------------------------------
  logic [CLW-1:0] nxt_col;
  logic [RLW-1:0] shoot_row;
  logic [IW-1:0]  shooter_next;
  logic           found;
  int             cand;

  always_comb begin
    nxt_col   = shoot_col_reg;
    found     = 1'b0;
    cand      = 0;
    shoot_row = '0;
    for (int k = 1; k <= COLS; k++) begin
      cand = (int'(shoot_col_reg) + k) % COLS;
      if (!found && col_alive[cand]) begin
        nxt_col = CLW'(cand);
        found   = 1'b1;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (alive_reg[r*COLS + int'(nxt_col)]) shoot_row = RLW'(r);
    end
    shooter_next = IW'(int'(shoot_row) * COLS + int'(nxt_col));
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic invade_set;
  logic step_fire;
  logic kill_ok;

  // The origin is only final one cycle after a step, so invasion is judged
  // on the registered origin while step_pulse is high.
  assign invade_set = step_pulse_reg && invade_cond && !invaded_reg;

  assign step_fire = (state_reg == MARCH) && tick_done && any_alive &&
                     !invaded_reg && !invade_set && !start;

  assign kill_ok = kill_valid && !start && (state_reg != HALT) &&
                   (32'(kill_idx) < 32'(N)) && alive_reg[kill_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run) state_next = MARCH;
      MARCH: begin
        if (!any_alive || invaded_reg || invade_set) state_next = HALT;
        else if (!run)                               state_next = IDLE;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    if (start) state_next = IDLE;
  end

  // Tick counter: runs only in MARCH, holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else if (start) begin
      tick_cnt_reg <= '0;
    end else if (state_reg == MARCH) begin
      if (step_fire)       tick_cnt_reg <= '0;
      else if (!tick_done) tick_cnt_reg <= tick_cnt_reg + CW'(1);
    end
  end

  // Formation datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_x_reg      <= 11'(X0);
      base_y_reg      <= 11'(Y0);
      alive_reg       <= '1;
      dir_reg         <= 1'b0;
      step_pulse_reg  <= 1'b0;
      shooter_idx_reg <= '0;
      shoot_col_reg   <= '0;
      invaded_reg     <= 1'b0;
      dead_reg        <= '0;
    end else if (start) begin
      base_x_reg      <= 11'(X0);
      base_y_reg      <= 11'(Y0);
      alive_reg       <= '1;
      dir_reg         <= 1'b0;
      step_pulse_reg  <= 1'b0;
      shooter_idx_reg <= '0;
      shoot_col_reg   <= '0;
      invaded_reg     <= 1'b0;
      dead_reg        <= '0;
    end else begin
      step_pulse_reg <= step_fire;
      if (step_fire) begin
        base_x_reg      <= base_x_step;
        base_y_reg      <= base_y_step;
        dir_reg         <= dir_step;
        shoot_col_reg   <= nxt_col;
        shooter_idx_reg <= shooter_next;
      end
      // A kill in the same cycle as a step still lands; the step above has
      // already used the pre-kill bitmap.
      if (kill_ok) begin
        alive_reg[kill_idx] <= 1'b0;
        dead_reg            <= dead_reg + DW'(1);
      end
      if (invade_set) invaded_reg <= 1'b1;
    end
  end

  assign base_x        = base_x_reg;
  assign base_y        = base_y_reg;
  assign alive         = alive_reg;
  assign direction     = dir_reg;
  assign step_pulse    = step_pulse_reg;
  assign shooter_idx   = shooter_idx_reg;
  assign shooter_valid = any_alive;
  assign all_dead      = ~any_alive;
  assign invaded       = invaded_reg;

endmodule

// File: tb/tb_enemy_formation.sv
module tb_enemy_formation;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        run = 1'b0;
  logic        kill_valid = 1'b0;
  logic [4:0]  kill_idx = '0;
  logic [10:0] base_x, base_y;
  logic [23:0] alive;
  logic        direction, step_pulse, shooter_valid, all_dead, invaded;
  logic [4:0]  shooter_idx;

  always #5 clk = ~clk;

  enemy_formation #(
    .TICK_BASE(16),
    .TICK_MIN (4),
    .TICK_DEC (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .run          (run),
    .kill_valid   (kill_valid),
    .kill_idx     (kill_idx),
    .base_x       (base_x),
    .base_y       (base_y),
    .alive        (alive),
    .direction    (direction),
    .step_pulse   (step_pulse),
    .shooter_idx  (shooter_idx),
    .shooter_valid(shooter_valid),
    .all_dead     (all_dead),
    .invaded      (invaded)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard of expected steps
  // ---------------------------------------------------------------------------
  typedef struct {
    int bx;
    int by;
    int dir;
    int sidx;
    int gap;
  } step_t;

  step_t sb_q[$];
  step_t mon_e;
  int    cyc = 0;
  int    last_step = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (step_pulse === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_step", step_pulse, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("step_base_x", base_x, mon_e.bx);
          check_eq("step_base_y", base_y, mon_e.by);
          check_eq("step_dir", direction, mon_e.dir);
          check_eq("step_shooter", shooter_idx, mon_e.sidx);
          if (mon_e.gap != 0) check_eq("step_gap", cyc - last_step, mon_e.gap);
        end
        last_step = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model of the formation
  // ---------------------------------------------------------------------------
  int          m_bx, m_by, m_dir, m_col, m_dead;
  logic [23:0] m_alive;

  task automatic model_reset();
    m_bx = 150; m_by = 40; m_dir = 0; m_col = 0; m_dead = 0;
    m_alive = '1;
  endtask

  task automatic model_kill(input int idx);
    if (idx < 24 && m_alive[idx]) begin
      m_alive[idx] = 1'b0;
      m_dead++;
    end
  endtask

  task automatic model_push_step(input bit first);
    int    rc = -1;
    int    lc = -1;
    int    nc;
    int    br = 0;
    bit    found = 0;
    bit    dr;
    step_t e;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 3; r++)
        if (m_alive[r*8+c]) begin
          if (c > rc) rc = c;
          if (lc < 0 || c < lc) lc = c;
        end
    nc = m_col;
    for (int k = 1; k <= 8; k++) begin
      int cd;
      cd = (m_col + k) % 8;
      if (!found && (m_alive[cd] || m_alive[8+cd] || m_alive[16+cd])) begin
        nc = cd;
        found = 1;
      end
    end
    for (int r = 0; r < 3; r++) if (m_alive[r*8+nc]) br = r;
    m_col = nc;
    if (m_dir == 0) dr = (m_bx + rc*60 + 20 + 10) > 640;
    else            dr = (m_bx + lc*60) < 10;
    if (dr) begin
      m_by  = m_by + 20;
      m_dir = 1 - m_dir;
    end else if (m_dir == 1) begin
      m_bx = m_bx - 10;
    end else begin
      m_bx = m_bx + 10;
    end
    e.bx   = m_bx;
    e.by   = m_by;
    e.dir  = m_dir;
    e.sidx = br*8 + nc;
    e.gap  = first ? 0 : ((16 - m_dead) < 4 ? 4 : 16 - m_dead);
    sb_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_steps(input int budget);
    int n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb_q.size() > 0) begin
      check_eq("step_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic drive_kill(input int idx, input bit update_model);
    kill_valid = 1'b1;
    kill_idx   = 5'(idx);
    @(posedge clk); #2;
    kill_valid = 1'b0;
    if (update_model) model_kill(idx);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values();
    check_eq("rst_base_x", base_x, 150);
    check_eq("rst_base_y", base_y, 40);
    check_eq("rst_alive", alive, 24'hFFFFFF);
    check_eq("rst_direction", direction, 0);
    check_eq("rst_step_pulse", step_pulse, 0);
    check_eq("rst_shooter_idx", shooter_idx, 0);
    check_eq("rst_shooter_valid", shooter_valid, 1);
    check_eq("rst_all_dead", all_dead, 0);
    check_eq("rst_invaded", invaded, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check_reset_values();
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();

    // Full grid: five moves right, then turn and drop
    for (int i = 0; i < 6; i++) model_push_step(i == 0);
    run = 1'b1;
    wait_steps(200);
    check_eq("a_end_base_x", base_x, 200);
    check_eq("a_end_base_y", base_y, 60);
    check_eq("a_end_dir", direction, 1);
    run = 1'b0;
    pulse_start();
    check_eq("start_base_x", base_x, 150);
    check_eq("start_dir", direction, 0);

    // Right column cleared: turn happens further right
    drive_kill(7, 1);
    drive_kill(15, 1);
    drive_kill(23, 1);
    check_eq("b_alive", alive, m_alive);
    for (int i = 0; i < 12; i++) model_push_step(i == 0);
    run = 1'b1;
    wait_steps(400);
    check_eq("b_drop_x", base_x, 260);
    run = 1'b0;
    pulse_start();

    // Speed-up, duplicate kill and out-of-range index
    for (int i = 0; i < 5; i++) drive_kill(i, 1);
    drive_kill(3, 1);
    drive_kill(24, 1);
    check_eq("c_alive", alive, m_alive);
    for (int i = 0; i < 4; i++) model_push_step(i == 0);
    run = 1'b1;
    wait_steps(200);
    run = 1'b0;
    pulse_start();

    // March to the invasion line
    begin
      bit first = 1;
      while (m_by < 280) begin
        model_push_step(first);
        first = 0;
      end
    end
    run = 1'b1;
    wait_steps(6000);
    check_eq("d_invaded_step_cycle", invaded, 0);
    @(posedge clk); #2;
    check_eq("d_invaded", invaded, 1);
    repeat (40) @(posedge clk);
    #2;
    check_eq("d_frozen_x", base_x, m_bx);
    check_eq("d_frozen_y", base_y, 280);
    check_eq("d_invaded_sticky", invaded, 1);
    drive_kill(0, 0);
    check_eq("d_halt_kill_ignored", alive, m_alive);
    run = 1'b0;
    pulse_start();
    check_eq("d_start_invaded", invaded, 0);

    // Wipe-out
    for (int i = 0; i < 24; i++) begin
      drive_kill(i, 1);
      if (i == 22) begin
        check_eq("e_one_left_all_dead", all_dead, 0);
        check_eq("e_one_left_valid", shooter_valid, 1);
      end
    end
    check_eq("e_alive", alive, 0);
    check_eq("e_all_dead", all_dead, 1);
    check_eq("e_shooter_valid", shooter_valid, 0);
    pulse_start();
    check_eq("e_alive_restored", alive, 24'hFFFFFF);
    check_eq("e_base_x", base_x, 150);
    check_eq("e_base_y", base_y, 40);
    check_eq("e_all_dead_clr", all_dead, 0);

    // Asynchronous reset in the middle of a march
    for (int i = 0; i < 2; i++) model_push_step(i == 0);
    run = 1'b1;
    wait_steps(100);
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values();
    sb_q.delete();
    run = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
